// File: rtl/pixel_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fetch_scheduler
// Description : Per-pixel sprite fetch scheduler. Walks the covering layers
//               in priority order, issues one SRAM palette-index read per
//               layer, and stops at the first non-transparent index. The
//               winning object ID and encoded color are handed downstream
//               over a valid/ready handshake.
//               Optional macro PIXEL_SCHED_STATS_EN adds saturating fetch
//               and fallback counters (o_fetch_cnt, o_fallback_cnt).
// Revision    : 1.0 - initial release
// ============================================================================

package sram_pkg;
    localparam int COLOR_WIDTH = 8;
endpackage

package game_pkg;
    typedef logic [3:0] ObjectID;
    // Background map object, shown when no layer is opaque.
    localparam ObjectID OBJECT_MAP = 4'd0;
endpackage

module pixel_fetch_scheduler #(
    parameter int                     NUM_LAYERS      = 4,
    parameter int                     ADDR_WIDTH      = 20,
    parameter int                     COLOR_WIDTH     = sram_pkg::COLOR_WIDTH,
    parameter logic [COLOR_WIDTH-1:0] TRANSPARENT_IDX = '0
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_pix_valid,
    output logic                                   o_pix_ready,
    input  logic [NUM_LAYERS-1:0]                  i_layer_hit,
    input  game_pkg::ObjectID [NUM_LAYERS-1:0]     i_layer_obj,
    input  logic [NUM_LAYERS-1:0][ADDR_WIDTH-1:0]  i_layer_addr,
    output logic                                   o_sram_req,
    output logic [ADDR_WIDTH-1:0]                  o_sram_addr,
    input  logic                                   i_sram_gnt,
    input  logic                                   i_sram_rvalid,
    input  logic [COLOR_WIDTH-1:0]                 i_sram_rdata,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output game_pkg::ObjectID                      o_object_id,
    output logic [COLOR_WIDTH-1:0]                 o_encoded_color
`ifdef PIXEL_SCHED_STATS_EN
    ,
    output logic [15:0]                            o_fetch_cnt,
    output logic [15:0]                            o_fallback_cnt
`endif
);

    localparam int c_sel_width = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                                r_state;
    state_t                                w_state_next;
    logic [NUM_LAYERS-1:0]                 r_pending;
    logic [NUM_LAYERS-1:0]                 w_pending_lsb;
    game_pkg::ObjectID [NUM_LAYERS-1:0]    r_obj;
    logic [NUM_LAYERS-1:0][ADDR_WIDTH-1:0] r_addr;
    logic [c_sel_width-1:0]                r_sel;
    logic [c_sel_width-1:0]                w_sel;
    game_pkg::ObjectID                     r_object_id;
    logic [COLOR_WIDTH-1:0]                r_color;
    logic                                  w_accept;
    logic                                  w_grant;
    logic                                  w_capture;
    logic                                  w_fallback;

    // Highest-priority (lowest index) layer still waiting to be fetched.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = c_sel_width'(i);
            end
        end
        w_pending_lsb = r_pending & (~r_pending + NUM_LAYERS'(1));
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake/request outputs.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
        w_fallback   = 1'b0;
        o_pix_ready  = 1'b0;
        o_sram_req   = 1'b0;
        o_sram_addr  = '0;
        o_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                // Ready is masked while reset is held so nothing is accepted.
                o_pix_ready = ~i_rst;
                if (i_pix_valid && !i_rst) begin
                    w_accept = 1'b1;
                    if (|i_layer_hit) begin
                        w_state_next = ISSUE;
                    end else begin
                        w_fallback   = 1'b1;
                        w_state_next = OUT;
                    end
                end
            end
            ISSUE: begin
                // Pending mask is frozen until grant, so addr stays stable.
                o_sram_req  = 1'b1;
                o_sram_addr = r_addr[w_sel];
                if (i_sram_gnt) begin
                    w_grant      = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (i_sram_rvalid) begin
                    if (i_sram_rdata != TRANSPARENT_IDX) begin
                        w_capture    = 1'b1;
                        w_state_next = OUT;
                    end else if (|r_pending) begin
                        w_state_next = ISSUE;
                    end else begin
                        w_fallback   = 1'b1;
                        w_state_next = OUT;
                    end
                end
            end
            OUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pixel context capture, pending-mask walk and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending   <= '0;
            r_obj       <= '0;
            r_addr      <= '0;
            r_sel       <= '0;
            r_object_id <= game_pkg::OBJECT_MAP;
            r_color     <= '0;
        end else begin
            if (w_accept) begin
                r_pending <= i_layer_hit;
                r_obj     <= i_layer_obj;
                r_addr    <= i_layer_addr;
            end
            if (w_grant) begin
                r_pending <= r_pending & ~w_pending_lsb;
                r_sel     <= w_sel;
            end
            if (w_capture) begin
                r_object_id <= r_obj[r_sel];
                r_color     <= i_sram_rdata;
            end
            if (w_fallback) begin
                r_object_id <= game_pkg::OBJECT_MAP;
                r_color     <= '0;
            end
        end
    end

    assign o_object_id     = r_object_id;
    assign o_encoded_color = r_color;

`ifdef PIXEL_SCHED_STATS_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_fallback_cnt;

    // Saturating counters of SRAM grants and fallback results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_cnt    <= '0;
            r_fallback_cnt <= '0;
        end else begin
            if (w_grant && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_fallback && (r_fallback_cnt != 16'hFFFF)) begin
                r_fallback_cnt <= r_fallback_cnt + 16'd1;
            end
        end
    end

    assign o_fetch_cnt    = r_fetch_cnt;
    assign o_fallback_cnt = r_fallback_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_fetch_scheduler
// Description : Self-checking bench for pixel_fetch_scheduler. Table-driven
//               pixel vectors against a small SRAM responder, plus directed
//               reset and stall sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_fetch_scheduler;

    logic                       i_clk;
    logic                       i_rst;
    logic                       i_pix_valid;
    logic                       o_pix_ready;
    logic [3:0]                 i_layer_hit;
    game_pkg::ObjectID [3:0]    i_layer_obj;
    logic [3:0][19:0]           i_layer_addr;
    logic                       o_sram_req;
    logic [19:0]                o_sram_addr;
    logic                       i_sram_gnt;
    logic                       i_sram_rvalid;
    logic [7:0]                 i_sram_rdata;
    logic                       o_valid;
    logic                       i_ready;
    game_pkg::ObjectID          o_object_id;
    logic [7:0]                 o_encoded_color;
`ifdef PIXEL_SCHED_STATS_EN
    logic [15:0]                o_fetch_cnt;
    logic [15:0]                o_fallback_cnt;
`endif

    pixel_fetch_scheduler dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_pix_valid     (i_pix_valid),
        .o_pix_ready     (o_pix_ready),
        .i_layer_hit     (i_layer_hit),
        .i_layer_obj     (i_layer_obj),
        .i_layer_addr    (i_layer_addr),
        .o_sram_req      (o_sram_req),
        .o_sram_addr     (o_sram_addr),
        .i_sram_gnt      (i_sram_gnt),
        .i_sram_rvalid   (i_sram_rvalid),
        .i_sram_rdata    (i_sram_rdata),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_object_id     (o_object_id),
        .o_encoded_color (o_encoded_color)
`ifdef PIXEL_SCHED_STATS_EN
        ,
        .o_fetch_cnt     (o_fetch_cnt),
        .o_fallback_cnt  (o_fallback_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]      hit;
        logic [3:0][7:0] data;
        int              gnt_wait;
        int              ready_wait;
        int              exp_lat;
        int              exp_reads;
        int              exp_first;
        int              exp_last;
        logic [3:0]      exp_obj;
        logic [7:0]      exp_color;
    } vec_t;

    localparam int c_num_vecs = 9;
    vec_t vecs [c_num_vecs];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] addr_of(input int v, input int l);
        return 20'((l + 1) * 65536 + v);
    endfunction

    task automatic add_vec(input int i, input logic [3:0] hit,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input int gw, input int rw, input int lat, input int reads,
                           input int first, input int last,
                           input logic [3:0] obj, input logic [7:0] col);
        vecs[i].hit        = hit;
        vecs[i].data       = {d3, d2, d1, d0};
        vecs[i].gnt_wait   = gw;
        vecs[i].ready_wait = rw;
        vecs[i].exp_lat    = lat;
        vecs[i].exp_reads  = reads;
        vecs[i].exp_first  = first;
        vecs[i].exp_last   = last;
        vecs[i].exp_obj    = obj;
        vecs[i].exp_color  = col;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // One pixel: accept, serve SRAM reads from the table, drain the result.
    task automatic run_vec(input int v);
        int         cyc, wcnt, rcnt, nreads, first_l, last_l, rv_layer, lat;
        bit         rv_pend, done, seen_valid;
        logic [19:0] prev_addr;
        logic [3:0]  got_obj;
        logic [7:0]  got_col;
        chk($sformatf("v%0d_pix_ready", v), 32'(o_pix_ready), 32'd1);
        i_pix_valid = 1'b1;
        i_layer_hit = vecs[v].hit;
        for (int l = 0; l < 4; l++) begin
            i_layer_obj[l]  = 4'(l + 5);
            i_layer_addr[l] = addr_of(v, l);
        end
        step();
        // Scramble inputs: the pixel in flight must use the accepted copy.
        i_pix_valid = 1'b0;
        i_layer_hit = ~vecs[v].hit;
        for (int l = 0; l < 4; l++) begin
            i_layer_obj[l]  = 4'hF;
            i_layer_addr[l] = 20'hFFFFF;
        end
        cyc = 1; wcnt = 0; rcnt = 0; nreads = 0; first_l = -1; last_l = -1;
        rv_layer = -1; lat = -1; rv_pend = 0; done = 0; seen_valid = 0;
        prev_addr = '0; got_obj = '0; got_col = '0;
        while (!done && cyc < 60) begin
            i_sram_gnt    = 1'b0;
            i_sram_rvalid = 1'b0;
            i_sram_rdata  = 8'h00;
            i_ready       = 1'b0;
            if (rv_pend) begin
                i_sram_rvalid = 1'b1;
                i_sram_rdata  = (rv_layer >= 0) ? vecs[v].data[rv_layer] : 8'hEE;
                rv_pend       = 0;
            end
            if (o_sram_req) begin
                if (wcnt > 0) chk($sformatf("v%0d_addr_stable", v), 32'(o_sram_addr), 32'(prev_addr));
                prev_addr = o_sram_addr;
                if (wcnt == vecs[v].gnt_wait) begin
                    i_sram_gnt = 1'b1;
                    nreads++;
                    rv_layer = -1;
                    for (int l = 0; l < 4; l++)
                        if (o_sram_addr == addr_of(v, l)) rv_layer = l;
                    if (nreads == 1) first_l = rv_layer;
                    last_l  = rv_layer;
                    rv_pend = 1;
                    wcnt    = 0;
                end else begin
                    wcnt++;
                end
            end
            if (o_valid) begin
                chk($sformatf("v%0d_out_pix_ready", v), 32'(o_pix_ready), 32'd0);
                if (!seen_valid) begin
                    seen_valid = 1;
                    lat     = cyc;
                    got_obj = o_object_id;
                    got_col = o_encoded_color;
                end else begin
                    chk($sformatf("v%0d_hold_obj", v), 32'(o_object_id), 32'(got_obj));
                    chk($sformatf("v%0d_hold_col", v), 32'(o_encoded_color), 32'(got_col));
                end
                if (rcnt < vecs[v].ready_wait) rcnt++;
                else begin
                    i_ready = 1'b1;
                    done    = 1;
                end
            end
            step();
            cyc++;
        end
        i_ready       = 1'b0;
        i_sram_gnt    = 1'b0;
        i_sram_rvalid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL v%0d_timeout: got no result expected o_valid within 60 cycles", v);
        end
        chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
        chk($sformatf("v%0d_reads", v), 32'(nreads), 32'(vecs[v].exp_reads));
        chk($sformatf("v%0d_first_layer", v), 32'(first_l), 32'(vecs[v].exp_first));
        chk($sformatf("v%0d_last_layer", v), 32'(last_l), 32'(vecs[v].exp_last));
        chk($sformatf("v%0d_object_id", v), 32'(got_obj), 32'(vecs[v].exp_obj));
        chk($sformatf("v%0d_color", v), 32'(got_col), 32'(vecs[v].exp_color));
        chk($sformatf("v%0d_idle_valid", v), 32'(o_valid), 32'd0);
        chk($sformatf("v%0d_idle_pix_ready", v), 32'(o_pix_ready), 32'd1);
    endtask

    initial begin
        int exp_fetch;
        //         idx hit      d0     d1     d2     d3    gw rw lat rd fst lst obj   col
        add_vec(0, 4'b0001, 8'h05, 8'h00, 8'h00, 8'h00, 0, 0, 3, 1,  0,  0, 4'd5, 8'h05);
        add_vec(1, 4'b1010, 8'h00, 8'h00, 8'h00, 8'h09, 0, 0, 5, 2,  1,  3, 4'd8, 8'h09);
        add_vec(2, 4'b0110, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 5, 2,  1,  2, 4'd0, 8'h00);
        add_vec(3, 4'b0001, 8'h03, 8'h00, 8'h00, 8'h00, 5, 0, 8, 1,  0,  0, 4'd5, 8'h03);
        add_vec(4, 4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 1, 0, -1, -1, 4'd0, 8'h00);
        add_vec(5, 4'b0100, 8'h00, 8'h00, 8'h7F, 8'h00, 0, 3, 3, 1,  2,  2, 4'd7, 8'h7F);
        add_vec(6, 4'b1111, 8'h00, 8'h00, 8'hAB, 8'h01, 0, 0, 7, 3,  0,  2, 4'd7, 8'hAB);
        add_vec(7, 4'b1100, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 7, 2,  2,  3, 4'd0, 8'h00);
        add_vec(8, 4'b1111, 8'hFF, 8'h01, 8'h02, 8'h03, 0, 0, 3, 1,  0,  0, 4'd5, 8'hFF);

        i_rst = 1'b1; i_pix_valid = 1'b0; i_layer_hit = '0; i_layer_obj = '0;
        i_layer_addr = '0; i_sram_gnt = 1'b0; i_sram_rvalid = 1'b0;
        i_sram_rdata = '0; i_ready = 1'b0;
        repeat (3) step();
        chk("rst_pix_ready", 32'(o_pix_ready), 32'd0);
        chk("rst_sram_req", 32'(o_sram_req), 32'd0);
        chk("rst_sram_addr", 32'(o_sram_addr), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_object_id", 32'(o_object_id), 32'(game_pkg::OBJECT_MAP));
        chk("rst_color", 32'(o_encoded_color), 32'd0);
        i_rst = 1'b0;
        #1;
        chk("post_rst_pix_ready", 32'(o_pix_ready), 32'd1);

        exp_fetch = 0;
        for (int v = 0; v < c_num_vecs; v++) begin
            run_vec(v);
            exp_fetch += vecs[v].exp_reads;
        end
`ifdef PIXEL_SCHED_STATS_EN
        chk("stats_fetch_cnt", 32'(o_fetch_cnt), 32'(exp_fetch));
        chk("stats_fallback_cnt", 32'(o_fallback_cnt), 32'd3);
`endif

        // Reset while a read is outstanding; the late rvalid must be ignored.
        i_pix_valid = 1'b1; i_layer_hit = 4'b0001;
        i_layer_obj[0] = 4'd5; i_layer_addr[0] = addr_of(0, 0);
        step();
        i_pix_valid = 1'b0;
        chk("rw_issue_req", 32'(o_sram_req), 32'd1);
        i_sram_gnt = 1'b1;
        step();
        i_sram_gnt = 1'b0;
        chk("rw_wait_req", 32'(o_sram_req), 32'd0);
        chk("rw_wait_pix_ready", 32'(o_pix_ready), 32'd0);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_sram_rvalid = 1'b1; i_sram_rdata = 8'h05;
        #1;
        chk("rw_idle_pix_ready", 32'(o_pix_ready), 32'd1);
        step();
        i_sram_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rw_late_valid%0d", k), 32'(o_valid), 32'd0);
            chk($sformatf("rw_late_req%0d", k), 32'(o_sram_req), 32'd0);
            chk($sformatf("rw_late_obj%0d", k), 32'(o_object_id), 32'(game_pkg::OBJECT_MAP));
            step();
        end
        run_vec(0);
`ifdef PIXEL_SCHED_STATS_EN
        chk("stats_fetch_after_rst", 32'(o_fetch_cnt), 32'd1);
        chk("stats_fallback_after_rst", 32'(o_fallback_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
